// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
// Holds the 2-bit saturating counter encoding, the value every pattern-history
// entry takes on reset, and a saturating increment for the statistics counters.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Increments by one but holds at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// Combinational next-state function for one 2-bit saturating counter.
// Ports:
//   cur   - current counter value
//   taken - resolved outcome; 1 moves toward ST, 0 moves toward SNT
//   nxt   - next counter value, held at ST/SNT at the ends
module bp_sat_counter2
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2**PHT_BITS 2-bit saturating counters
// indexed by instruction word address, with execute-stage resolution and
// resolved/mispredicted branch statistics.
// Ports:
//   clk, rst       - clock; asynchronous active-high reset
//   pcD, branchD   - decode-stage lookup; pred_takeD is the prediction
//   stallE         - execute stage held; the table only updates when released
//   pcE, branchE   - execute-stage branch being resolved
//   pred_takeE     - prediction that travelled with the branch
//   actual_takeE   - resolved outcome
//   pc_branchE     - branch target
//   pc_plus4E      - delay-slot address
//   mispredE       - prediction was wrong, fetch must be redirected
//   redirect_pcE   - correct next fetch address
//   branch_cnt     - number of resolved branches (saturating)
//   mispred_cnt    - number of mispredicted branches (saturating)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcD,
  input  logic        branchD,
  output logic        pred_takeD,
  input  logic        stallE,
  input  logic [31:0] pcE,
  input  logic        branchE,
  input  logic        pred_takeE,
  input  logic        actual_takeE,
  input  logic [31:0] pc_branchE,
  input  logic [31:0] pc_plus4E,
  output logic        mispredE,
  output logic [31:0] redirect_pcE,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int PHT_ENTRIES = 2 ** PHT_BITS;

  ctr_t pht_q [PHT_ENTRIES];
  ctr_t pht_d [PHT_ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [PHT_BITS-1:0] rd_idx;
  logic [PHT_BITS-1:0] upd_idx;
  logic                commit;
  ctr_t                upd_cur;
  ctr_t                upd_nxt;

  // Instructions are word aligned, so the two low pc bits carry no information.
  assign rd_idx  = pcD[PHT_BITS+1:2];
  assign upd_idx = pcE[PHT_BITS+1:2];

  // A stalled branch is seen on several cycles; only the releasing cycle counts.
  assign commit  = branchE & ~stallE;

  // Reads come straight from the flops, so a same-cycle update is not visible
  // until the next cycle.
  assign pred_takeD = branchD & pht_q[rd_idx][1];

  assign mispredE     = branchE & (pred_takeE ^ actual_takeE);
  // Not-taken resumes after the delay slot, which has already been fetched.
  assign redirect_pcE = actual_takeE ? pc_branchE : (pc_plus4E + 32'd4);

  assign upd_cur = pht_q[upd_idx];

  bp_sat_counter2 u_sat_counter2 (
    .cur   (upd_cur),
    .taken (actual_takeE),
    .nxt   (upd_nxt)
  );

  always_comb begin
    pht_d = pht_q;
    if (commit) begin
      pht_d[upd_idx] = upd_nxt;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (commit) begin
      branch_cnt_d = sat_inc32(branch_cnt_q);
      if (mispredE) begin
        mispred_cnt_d = sat_inc32(mispred_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CTR_RESET;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pht_q         <= pht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD;
  logic        pred_takeD;
  logic        stallE;
  logic [31:0] pcE;
  logic        branchE;
  logic        pred_takeE;
  logic        actual_takeE;
  logic [31:0] pc_branchE;
  logic [31:0] pc_plus4E;
  logic        mispredE;
  logic [31:0] redirect_pcE;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  branch_predictor #(.PHT_BITS(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcD          (pcD),
    .branchD      (branchD),
    .pred_takeD   (pred_takeD),
    .stallE       (stallE),
    .pcE          (pcE),
    .branchE      (branchE),
    .pred_takeE   (pred_takeE),
    .actual_takeE (actual_takeE),
    .pc_branchE   (pc_branchE),
    .pc_plus4E    (pc_plus4E),
    .mispredE     (mispredE),
    .redirect_pcE (redirect_pcE),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Looks up pc in decode and compares the prediction.
  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    pcD = pc;
    branchD = 1'b1;
    #1;
    chk(tag, {31'd0, pred_takeD}, {31'd0, exp});
  endtask

  // One unstalled branch resolution; returns 1 ns after the committing edge.
  task automatic do_commit(input logic [31:0] pc, input logic taken, input logic pred);
    pcE = pc;
    actual_takeE = taken;
    pred_takeE = pred;
    branchE = 1'b1;
    stallE = 1'b0;
    @(posedge clk);
    #1;
    branchE = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pcD = 32'h0000_0010; branchD = 1'b1;
    stallE = 1'b0; pcE = 32'h0000_0080; branchE = 1'b1;
    pred_takeE = 1'b0; actual_takeE = 1'b1;
    pc_branchE = 32'h0000_1234; pc_plus4E = 32'h0000_0104;

    // In reset: a pending commit is discarded, combinational outputs still follow.
    #2;
    chk("rst_pred", {31'd0, pred_takeD}, 32'd0);
    chk("rst_mispred", {31'd0, mispredE}, 32'd1);
    chk("rst_redirect", redirect_pcE, 32'h0000_1234);
    @(posedge clk); #1;
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);

    branchE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh table predicts weakly not taken.
    chk_pred("init_pred_b1", 32'h0000_0010, 1'b0);
    branchD = 1'b0;
    #1;
    chk("init_pred_b0", {31'd0, pred_takeD}, 32'd0);

    // 01 -> 10 -> 11
    do_commit(32'h0000_0040, 1'b1, 1'b0);
    chk_pred("pred_after_1T", 32'h0000_0040, 1'b1);
    do_commit(32'h0000_0040, 1'b1, 1'b1);
    chk("cnt_after_2", branch_cnt, 32'd2);
    chk("mcnt_after_2", mispred_cnt, 32'd1);

    // Saturate at 11, then walk down 11 -> 10 -> 01.
    for (int i = 0; i < 3; i++) do_commit(32'h0000_0040, 1'b1, 1'b1);
    do_commit(32'h0000_0040, 1'b0, 1'b1);
    chk_pred("pred_after_sat_NT", 32'h0000_0040, 1'b1);
    do_commit(32'h0000_0040, 1'b0, 1'b1);
    chk_pred("pred_after_2NT", 32'h0000_0040, 1'b0);
    chk("cnt_after_7", branch_cnt, 32'd7);
    chk("mcnt_after_7", mispred_cnt, 32'd3);

    // Branch stalled three cycles, released on the fourth.
    pcE = 32'h0000_0080; pc_branchE = 32'h0000_2000;
    pred_takeE = 1'b0; actual_takeE = 1'b1;
    branchE = 1'b1; stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mispred", {31'd0, mispredE}, 32'd1);
      chk("stall_branch_cnt", branch_cnt, 32'd7);
      @(posedge clk); #1;
    end
    stallE = 1'b0;
    #1;
    chk("release_mispred", {31'd0, mispredE}, 32'd1);
    chk("release_redirect", redirect_pcE, 32'h0000_2000);
    @(posedge clk); #1;
    branchE = 1'b0;
    chk("stall_branch_cnt_end", branch_cnt, 32'd8);
    chk("stall_mispred_cnt_end", mispred_cnt, 32'd4);
    chk_pred("stall_pred", 32'h0000_0080, 1'b1);

    // Not-taken redirect skips the delay slot, wrapping at 32 bits.
    // branchE stays low, so these cycles are bubbles that must change nothing.
    actual_takeE = 1'b0;
    pc_plus4E = 32'h0000_0104;
    #1;
    chk("redirect_nt", redirect_pcE, 32'h0000_0108);
    pc_plus4E = 32'hFFFF_FFFC;
    #1;
    chk("redirect_wrap", redirect_pcE, 32'h0000_0000);
    chk("bubble_mispred", {31'd0, mispredE}, 32'd0);
    @(posedge clk); #1;
    chk("bubble_branch_cnt", branch_cnt, 32'd8);
    chk_pred("bubble_pred", 32'h0000_0040, 1'b0);

    // Same-cycle read and commit at index 5: old value seen first.
    pcD = 32'h0000_0014; branchD = 1'b1;
    pcE = 32'h0000_0014; actual_takeE = 1'b1; pred_takeE = 1'b0;
    branchE = 1'b1; stallE = 1'b0;
    #1;
    chk("collide_pred_same", {31'd0, pred_takeD}, 32'd0);
    @(posedge clk); #1;
    branchE = 1'b0;
    chk("collide_pred_next", {31'd0, pred_takeD}, 32'd1);

    // Reset mid-sequence with a commit pending.
    pcE = 32'h0000_0080; actual_takeE = 1'b1; pred_takeE = 1'b0;
    branchE = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_branch_cnt", branch_cnt, 32'd0);
    chk("mid_rst_mispred_cnt", mispred_cnt, 32'd0);
    chk_pred("mid_rst_pred_14", 32'h0000_0014, 1'b0);
    @(posedge clk); #1;
    chk_pred("mid_rst_pred_80", 32'h0000_0080, 1'b0);
    chk("mid_rst_cnt_held", branch_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    branchE = 1'b0;
    chk("post_rst_branch_cnt", branch_cnt, 32'd1);
    chk("post_rst_mispred_cnt", mispred_cnt, 32'd1);
    chk_pred("post_rst_pred_80", 32'h0000_0080, 1'b1);
    chk_pred("post_rst_pred_14", 32'h0000_0014, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PHT_BITS, default 6, meaning log2 of pattern-history-table entries.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pcD  input  32  decode-stage instruction address.
REQ-005 SHALL have port branchD  input  1  decode-stage instruction is a conditional branch.
REQ-006 SHALL have port pred_takeD  output  1  predicted taken for the decode-stage branch.
REQ-007 SHALL have port stallE  input  1  execute stage held this cycle.
REQ-008 SHALL have port pcE  input  32  execute-stage instruction address.
REQ-009 SHALL have port branchE  input  1  execute-stage instruction is a conditional branch.
REQ-010 SHALL have port pred_takeE  input  1  prediction carried down the ID/EX register.
REQ-011 SHALL have port actual_takeE  input  1  branch outcome resolved in execute.
REQ-012 SHALL have port pc_branchE  input  32  branch target.
REQ-013 SHALL have port pc_plus4E  input  32  address of the delay slot.
REQ-014 SHALL have port mispredE  output  1  prediction wrong, redirect fetch.
REQ-015 SHALL have port redirect_pcE  output  32  correct next-fetch address.
REQ-016 SHALL have port branch_cnt  output  32  resolved-branch count.
REQ-017 SHALL have port mispred_cnt  output  32  mispredicted-branch count.

Function
REQ-018 SHALL hold a PHT of 2**PHT_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 SHALL index the PHT by pc[PHT_BITS+1:2], using pcD for reads and pcE for updates.
REQ-020 SHALL drive pred_takeD = branchD AND counter[1] of the indexed entry, combinationally, with zero latency.
REQ-021 SHALL drive mispredE = branchE AND (pred_takeE XOR actual_takeE), combinationally, and independent of stallE.
REQ-022 SHALL drive redirect_pcE = pc_branchE when actual_takeE, else pc_plus4E + 4 (skip the delay slot); 32-bit wrap.
REQ-023 SHALL perform an update commit only on a cycle with branchE=1 and stallE=0, giving exactly one commit per branch however long it stalls.
REQ-024 On commit, SHALL increment the indexed counter if actual_takeE and decrement it otherwise, saturating at 11 and 00.
REQ-025 On commit, SHALL increment branch_cnt, and SHALL also increment mispred_cnt when mispredE=1; both saturate at 0xFFFF_FFFF.
REQ-026 When the read and update index collide in the same cycle, the read SHALL return the pre-update value (no bypass).
REQ-027 The flushed-bubble case (branchE=0) SHALL cause no state change.

Reset
REQ-028 SHALL, on rst assertion, immediately set every PHT entry to 01 (weak-NT) and branch_cnt = mispred_cnt = 0.
REQ-029 SHALL, during reset, output pred_takeD = 0, with mispredE and redirect_pcE following their inputs combinationally.
REQ-030 Reset asserted mid-operation SHALL discard any commit in that cycle; the first commit is possible on the first edge after deassertion.

Structure
REQ-031 SHALL take the counter encodings (SNT, WNT, WT, ST) and the reset value WNT from shared package bp_pkg.
REQ-032 SHALL instantiate one sub-module, bp_sat_counter2: a combinational 2-bit saturating next-state function with inputs cur and taken and output nxt, used by the update path.
REQ-033 SHALL implement the PHT as flip-flops (asynchronous reset requirement); no SRAM macro.

Verification
REQ-034 Reset then pcD=0x0000_0010 with branchD=1 -> pred_takeD=0; with branchD=0 -> pred_takeD=0.
REQ-035 Two commits at pcE=0x0000_0040 with actual_takeE=1 -> the entry goes 01->10->11, and pred_takeD=1 at pcD=0x0000_0040 after the first commit.
REQ-036 Entry at 11 with three further taken commits -> the entry stays 11; then one not-taken commit -> 10, and pred_takeD still 1.
REQ-037 branchE=1, stallE=1 for 3 cycles, then stallE=0, with pred_takeE=0 and actual_takeE=1 -> mispredE=1 for all 4 cycles, branch_cnt=1, mispred_cnt=1, redirect_pcE=pc_branchE.
REQ-038 Not-taken resolution with pc_plus4E=0x0000_0104 -> redirect_pcE=0x0000_0108; with pc_plus4E=0xFFFF_FFFC -> redirect_pcE=0x0000_0000.
REQ-039 Same-cycle read and commit at index 5, entry 01, taken -> pred_takeD=0 that cycle and 1 the next; rst pulsed mid-sequence -> all counters read 01 and both statistics counters read 0.
